// File: rtl/spi_tx_framer.sv
// rtl/spi_tx_framer.sv - SPI transmit framer: byte FIFO payload followed by a CRC-8 trailer
module spi_tx_framer #(
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cs,
  input  logic [7:0]             i_frame_len,
  input  logic                   i_in_valid,
  input  logic [7:0]             i_in_byte,
  output logic                   o_in_ready,
  output logic                   o_tx_valid,
  output logic [7:0]             o_tx_byte,
  input  logic                   i_tx_ready,
  output logic                   o_busy,
  output logic                   o_overflow,
  output logic [$clog2(DEPTH):0] o_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CRC     = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    remaining_q;
  logic [7:0]    crc_q;
  logic          overflow_q;

  logic          start;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          abort;

  assign abort = i_cs;

  // CRC-8, poly 0x07, MSB first, whole byte folded in one cycle
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    o_in_ready = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_byte  = 8'h00;
    start      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    ovf_set    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!i_cs) begin
          start   = 1'b1;
          state_d = (i_frame_len == 8'd0) ? S_CRC : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        o_in_ready = (count_q < FULL_COUNT);
        o_tx_valid = (count_q != '0);
        o_tx_byte  = o_tx_valid ? mem[rd_ptr_q] : 8'h00;
        push       = i_in_valid && o_in_ready;
        ovf_set    = i_in_valid && !o_in_ready;
        pop        = o_tx_valid && i_tx_ready;
        if (pop && remaining_q == 8'd1) begin
          state_d = S_CRC;
        end
      end
      S_CRC: begin
        o_tx_valid = 1'b1;
        o_tx_byte  = crc_q;
        if (i_tx_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Chip-select release wins over any same-cycle push or pop
    if (abort) begin
      state_d = S_IDLE;
      start   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      ovf_set = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= 8'd0;
      crc_q       <= 8'h00;
      overflow_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (abort) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
          count_q <= count_q + CW'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CW'(1);
        end
      end

      if (start) begin
        remaining_q <= i_frame_len;
        crc_q       <= 8'h00;
        overflow_q  <= 1'b0;
      end else begin
        if (pop) begin
          remaining_q <= remaining_q - 8'd1;
          crc_q       <= crc8_next(crc_q, o_tx_byte);
        end
        if (ovf_set) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count
  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      mem[wr_ptr_q] <= i_in_byte;
    end
  end

  assign o_busy       = (state_q != S_IDLE);
  assign o_overflow   = overflow_q;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_spi_tx_framer.sv
// tb/tb_spi_tx_framer.sv - directed table and sequence bench for spi_tx_framer
module tb_spi_tx_framer;

  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic [7:0]    frame_len;
  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_ready;
  logic          tx_valid;
  logic [7:0]    tx_byte;
  logic          tx_ready;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  spi_tx_framer #(.DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cs         (cs),
    .i_frame_len  (frame_len),
    .i_in_valid   (in_valid),
    .i_in_byte    (in_byte),
    .o_in_ready   (in_ready),
    .o_tx_valid   (tx_valid),
    .o_tx_byte    (tx_byte),
    .i_tx_ready   (tx_ready),
    .o_busy       (busy),
    .o_overflow   (overflow),
    .o_fifo_count (fifo_count)
  );

  typedef struct {
    logic          cs;
    logic [7:0]    len;
    logic          iv;
    logic [7:0]    ib;
    logic          tr;
    logic          ev;
    logic [7:0]    eb;
    logic          eir;
    logic          ebusy;
    logic          eovf;
    logic [CW-1:0] ecnt;
  } vec_t;

  vec_t vecs[15];
  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic [7:0] l, input logic v, input logic [7:0] b,
                       input logic r);
    cs        = c;
    frame_len = l;
    in_valid  = v;
    in_byte   = b;
    tx_ready  = r;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [7:0] eb,
                            input logic eir, input logic ebusy, input logic eovf,
                            input logic [CW-1:0] ecnt);
    chk({tag, ".tx_valid"}, 32'(tx_valid), 32'(ev));
    chk({tag, ".tx_byte"}, 32'(tx_byte), 32'(eb));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(eir));
    chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eovf));
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(ecnt));
  endtask

  initial begin
    // cs, len, iv, ib, tr | tx_valid, tx_byte, in_ready, busy, overflow, count
    vecs[0]  = '{1'b1, 8'd2, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 8'd2, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 8'd2, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[3]  = '{1'b0, 8'd2, 1'b1, 8'h02, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 4'd1};
    vecs[4]  = '{1'b0, 8'd2, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 4'd1};
    vecs[5]  = '{1'b0, 8'd2, 1'b0, 8'h00, 1'b1, 1'b1, 8'h1B, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[6]  = '{1'b0, 8'd2, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[7]  = '{1'b1, 8'd2, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[8]  = '{1'b1, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[9]  = '{1'b0, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[10] = '{1'b0, 8'd0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[11] = '{1'b0, 8'd0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[12] = '{1'b0, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[13] = '{1'b1, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[14] = '{1'b1, 8'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0};

    rst = 1'b1;
    drive(1'b1, 8'd0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    expect_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    tick();

    // Nominal 2-byte frame, then zero-length frame
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].cs, vecs[i].len, vecs[i].iv, vecs[i].ib, vecs[i].tr);
      expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eb, vecs[i].eir,
                 vecs[i].ebusy, vecs[i].eovf, vecs[i].ecnt);
      tick();
    end

    // Overflow: nine pushes into an 8-deep FIFO with the slave stalled
    drive(1'b0, 8'd16, 1'b0, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 8'd16, 1'b1, 8'(8'h10 + i), 1'b0);
      if (i == 8) begin
        chk("ovf.in_ready_full", 32'(in_ready), 32'd0);
        chk("ovf.count_full", 32'(fifo_count), 32'd8);
      end
      tick();
    end
    drive(1'b0, 8'd16, 1'b0, 8'h00, 1'b0);
    expect_out("ovf", 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 4'd8);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'd16, 1'b0, 8'h00, 1'b1);
      chk($sformatf("ovf.drain%0d.valid", i), 32'(tx_valid), 32'd1);
      chk($sformatf("ovf.drain%0d.byte", i), 32'(tx_byte), 32'(8'h10 + i));
      tick();
    end
    expect_out("ovf.drained", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd0);

    // Reset pulse mid-frame with two bytes buffered and overflow set
    drive(1'b0, 8'd16, 1'b1, 8'hC0, 1'b0);
    tick();
    drive(1'b0, 8'd16, 1'b1, 8'hC1, 1'b0);
    tick();
    drive(1'b0, 8'd16, 1'b0, 8'h00, 1'b0);
    chk("rst.pre_count", 32'(fifo_count), 32'd2);
    rst = 1'b1;
    tick();
    expect_out("rst.mid", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    drive(1'b1, 8'd16, 1'b0, 8'h00, 1'b0);
    tick();
    expect_out("rst.idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 8'd16, 1'b0, 8'h00, 1'b0);
    tick();
    expect_out("rst.restart", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0);
    drive(1'b1, 8'd0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();

    // Simultaneous push and pop at count 3
    drive(1'b0, 8'd8, 1'b0, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'd8, 1'b1, 8'(8'hA0 + i), 1'b0);
      tick();
    end
    drive(1'b0, 8'd8, 1'b1, 8'hA3, 1'b1);
    chk("pp.pre_count", 32'(fifo_count), 32'd3);
    chk("pp.pre_head", 32'(tx_byte), 32'hA0);
    tick();
    drive(1'b0, 8'd8, 1'b0, 8'h00, 1'b1);
    chk("pp.post_count", 32'(fifo_count), 32'd3);
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, 8'd8, 1'b0, 8'h00, 1'b1);
      chk($sformatf("pp.order%0d", k), 32'(tx_byte), 32'(8'hA0 + k));
      tick();
    end
    chk("pp.empty", 32'(fifo_count), 32'd0);
    drive(1'b1, 8'd0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();

    // Abort after one of four bytes sent, two still buffered
    drive(1'b0, 8'd4, 1'b0, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'd4, 1'b1, 8'(8'hB0 + i), 1'b0);
      tick();
    end
    drive(1'b0, 8'd4, 1'b0, 8'h00, 1'b1);
    chk("abort.first", 32'(tx_byte), 32'hB0);
    tick();
    drive(1'b1, 8'd4, 1'b1, 8'hFF, 1'b1);
    chk("abort.pre_count", 32'(fifo_count), 32'd2);
    tick();
    expect_out("abort.idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);

    // Next frame CRC must restart from 0x00
    drive(1'b0, 8'd2, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 8'd2, 1'b1, 8'h01, 1'b0);
    tick();
    drive(1'b0, 8'd2, 1'b1, 8'h02, 1'b0);
    tick();
    drive(1'b0, 8'd2, 1'b0, 8'h00, 1'b1);
    chk("abort.next_b0", 32'(tx_byte), 32'h01);
    tick();
    chk("abort.next_b1", 32'(tx_byte), 32'h02);
    tick();
    chk("abort.next_crc_valid", 32'(tx_valid), 32'd1);
    chk("abort.next_crc", 32'(tx_byte), 32'h1B);
    tick();
    expect_out("abort.next_done", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
    drive(1'b1, 8'd0, 1'b0, 8'h00, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
